// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   state_e       : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W   : bits per BCD digit
//   digits_for()  : minimum decimal digit count for an unsigned bin_w-bit value
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Digits of 2^n - 1 = floor(n * log10(2)) + 1; 2^n is never a power of ten for n >= 1.
   function automatic int unsigned digits_for(input int unsigned bin_w);
      longint unsigned scaled;
      if (bin_w == 0) begin
         return 1;
      end
      scaled = longint'(bin_w) * 64'd3010299957;
      return int'(scaled / 64'd10000000000) + 1;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit corrector: digits >= 5 get +3 before the shift.
//   digit_i : current BCD digit
//   adj_c_o : corrected digit (4-bit add, carry discarded; valid digits never exceed 12)
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] adj_c_o
);

   always_comb begin
      adj_c_o = digit_i;
      if (digit_i >= BCD_DIGIT_W'(5)) begin
         adj_c_o = digit_i + BCD_DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/valid handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start, bin : conversion request and operand, sampled only while idle
//   busy       : conversion in progress (start ignored)
//   out_valid  : one-cycle pulse with each new result
//   bcd_out    : packed result, digit 0 in [3:0]; sign_out / ovf qualify it
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          out_valid,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          sign_out,
   output logic                          ovf
);

   localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   state_e             state_q, state_d;
   logic [BIN_W-1:0]   mag_q, mag_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   adj_c;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               ovf_st_q, ovf_st_d;
   logic               spill_c;
   logic               busy_d, valid_d, sign_d, ovf_d;
   logic [ACC_W-1:0]   bcd_d;

   // Per-digit add-3 correction of the accumulator
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .adj_c_o (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      mag_d    = mag_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      ovf_st_d = ovf_st_q;
      spill_c  = 1'b0;
      bcd_d    = bcd_out;
      sign_d   = sign_out;
      ovf_d    = ovf;
      valid_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // Modulo-2^BIN_W negate, so the most negative value maps to its magnitude
               if (SIGNED && bin[BIN_W-1]) begin
                  mag_d = BIN_W'(~bin) + BIN_W'(1);
               end else begin
                  mag_d = bin;
               end
               neg_d    = SIGNED & bin[BIN_W-1];
               acc_d    = '0;
               cnt_d    = '0;
               ovf_st_d = 1'b0;
            end
         end
         SHIFT: begin
            // Bit leaving the top digit means the value needs more than DIGITS digits
            {spill_c, acc_d} = {adj_c, mag_q[BIN_W-1]};
            mag_d    = {mag_q[BIN_W-2:0], 1'b0};
            ovf_st_d = ovf_st_q | spill_c;
            cnt_d    = cnt_q + CNT_W'(1);
         end
         DONE: begin
            bcd_d   = acc_q;
            sign_d  = neg_q;
            ovf_d   = ovf_st_q;
            valid_d = 1'b1;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mag_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         ovf_st_q  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         bcd_out   <= '0;
         sign_out  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         mag_q     <= mag_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         ovf_st_q  <= ovf_st_d;
         busy      <= busy_d;
         out_valid <= valid_d;
         bcd_out   <= bcd_d;
         sign_out  <= sign_d;
         ovf       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: four instances cover the default,
// two-digit (overflow), signed and 16-bit configurations.
module tb_bin2bcd_seq;

   typedef struct {
      logic [19:0] bcd;
      logic        sign;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0]  rst   = 4'hF;
   logic [3:0]  start = 4'h0;
   logic [7:0]  bin0 = '0, bin1 = '0, bin2 = '0;
   logic [15:0] bin3 = '0;
   logic [3:0]  busy, vld, sgn, ovf;
   logic [11:0] bcd0, bcd2;
   logic [7:0]  bcd1;
   logic [19:0] bcd3;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u_def (
      .clk(clk), .rst(rst[0]), .start(start[0]), .bin(bin0), .busy(busy[0]),
      .out_valid(vld[0]), .bcd_out(bcd0), .sign_out(sgn[0]), .ovf(ovf[0]));
   bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_d2 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .bin(bin1), .busy(busy[1]),
      .out_valid(vld[1]), .bcd_out(bcd1), .sign_out(sgn[1]), .ovf(ovf[1]));
   bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst[2]), .start(start[2]), .bin(bin2), .busy(busy[2]),
      .out_valid(vld[2]), .bcd_out(bcd2), .sign_out(sgn[2]), .ovf(ovf[2]));
   bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_wide (
      .clk(clk), .rst(rst[3]), .start(start[3]), .bin(bin3), .busy(busy[3]),
      .out_valid(vld[3]), .bcd_out(bcd3), .sign_out(sgn[3]), .ovf(ovf[3]));

   int checks = 0;
   int failures = 0;

   exp_t q0[$], q1[$], q2[$], q3[$];

   function automatic logic [19:0] bcd_of(input int i);
      case (i)
         0:       return 20'(bcd0);
         1:       return 20'(bcd1);
         2:       return 20'(bcd2);
         default: return bcd3;
      endcase
   endfunction

   function automatic void sb_push(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         2:       q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic int sb_size(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         2:       return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic exp_t sb_pop(input int i);
      case (i)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         2:       return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic set_bin(input int i, input logic [15:0] v);
      case (i)
         0:       bin0 = v[7:0];
         1:       bin1 = v[7:0];
         2:       bin2 = v[7:0];
         default: bin3 = v;
      endcase
   endtask

   // Monitor: every out_valid pops one expected result and checks its content and arrival cycle
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (vld[i] === 1'b1) begin
            if (sb_size(i) == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid dut%0d actual_bcd=%0h expected=no_valid", i, bcd_of(i));
            end else begin
               exp_t e;
               e = sb_pop(i);
               check($sformatf("bcd_dut%0d", i), 32'(bcd_of(i)), 32'(e.bcd));
               check($sformatf("sign_dut%0d", i), 32'(sgn[i]), 32'(e.sign));
               check($sformatf("ovf_dut%0d", i), 32'(ovf[i]), 32'(e.ovf));
               check($sformatf("latency_dut%0d", i), 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   task automatic wait_drain(input int i);
      int n;
      n = 0;
      while (sb_size(i) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_size(i) != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout_dut%0d actual_pending=%0d expected=0", i, sb_size(i));
         while (sb_size(i) != 0) void'(sb_pop(i));
      end
   endtask

   // One pulsed conversion; result lands w+1 clocks after the accept edge and must then hold
   task automatic conv(input int i, input int w, input logic [15:0] v,
                       input logic [19:0] eb, input logic es, input logic eo);
      exp_t e;
      @(negedge clk);
      set_bin(i, v);
      start[i] = 1'b1;
      e = '{eb, es, eo, cyc + w + 2};
      sb_push(i, e);
      @(negedge clk);
      start[i] = 1'b0;
      wait_drain(i);
      repeat (3) @(negedge clk);
      check($sformatf("hold_bcd_dut%0d", i), 32'(bcd_of(i)), 32'(eb));
   endtask

   initial begin
      exp_t e;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_busy_dut%0d", i), 32'(busy[i]), 32'd0);
         check($sformatf("rst_valid_dut%0d", i), 32'(vld[i]), 32'd0);
         check($sformatf("rst_bcd_dut%0d", i), 32'(bcd_of(i)), 32'd0);
         check($sformatf("rst_ovf_dut%0d", i), 32'(ovf[i]), 32'd0);
      end
      rst = 4'h0;

      conv(0, 8, 16'd255, 20'h255, 1'b0, 1'b0);
      conv(0, 8, 16'd0,   20'h000, 1'b0, 1'b0);
      conv(1, 8, 16'd255, 20'h55,  1'b0, 1'b1);
      conv(1, 8, 16'd99,  20'h99,  1'b0, 1'b0);
      conv(2, 8, 16'h80,  20'h128, 1'b1, 1'b0);
      conv(2, 8, 16'hFF,  20'h001, 1'b1, 1'b0);
      conv(2, 8, 16'h7F,  20'h127, 1'b0, 1'b0);

      // Wide conversion with an ignored start pulse while busy
      @(negedge clk);
      bin3 = 16'hFFFF;
      start[3] = 1'b1;
      e = '{20'h65535, 1'b0, 1'b0, cyc + 18};
      sb_push(3, e);
      @(negedge clk);
      start[3] = 1'b0;
      check("busy_wide_e0", 32'(busy[3]), 32'd1);
      for (int k = 1; k <= 16; k++) begin
         if (k == 5) begin
            start[3] = 1'b1;
            bin3 = 16'd1234;
         end else begin
            start[3] = 1'b0;
         end
         @(negedge clk);
         check($sformatf("busy_wide_k%0d", k), 32'(busy[3]), 32'd1);
      end
      wait_drain(3);
      check("busy_wide_after", 32'(busy[3]), 32'd0);

      // Reset three clocks into a conversion aborts it silently
      @(negedge clk);
      bin0 = 8'd200;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check("abort_busy", 32'(busy[0]), 32'd0);
      check("abort_valid", 32'(vld[0]), 32'd0);
      check("abort_bcd", 32'(bcd0), 32'd0);
      check("abort_sign", 32'(sgn[0]), 32'd0);
      check("abort_ovf", 32'(ovf[0]), 32'd0);
      repeat (12) @(negedge clk);
      conv(0, 8, 16'd42, 20'h042, 1'b0, 1'b0);

      // start held high: back-to-back conversions, bin re-sampled at each accept
      @(negedge clk);
      bin0 = 8'd10;
      start[0] = 1'b1;
      e = '{20'h010, 1'b0, 1'b0, cyc + 10};
      sb_push(0, e);
      @(negedge clk);
      bin0 = 8'd20;
      e = '{20'h020, 1'b0, 1'b0, cyc + 19};
      sb_push(0, e);
      repeat (10) @(negedge clk);
      bin0 = 8'd30;
      e = '{20'h030, 1'b0, 1'b0, cyc + 19};
      sb_push(0, e);
      repeat (10) @(negedge clk);
      start[0] = 1'b0;
      wait_drain(0);
      repeat (12) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         check($sformatf("sb_empty_dut%0d", i), 32'(sb_size(i)), 32'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
